// File: rtl/stack_drainer_if.sv
// Command, stack-side and output-stream signals of the LIFO drain engine.
// The drainer connects through the slave modport; its environment uses master.
interface stack_drainer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CNT_WIDTH-1:0]  cmd_count;
  logic                  cmd_all;
  logic                  stk_pop;
  logic [DATA_WIDTH-1:0] stk_data;
  logic                  stk_empty;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic                  underflow;
  logic [CNT_WIDTH-1:0]  drained_count;

  modport slave (
    input  cmd_valid, cmd_count, cmd_all, stk_data, stk_empty, out_ready,
    output cmd_ready, stk_pop, out_valid, out_data, out_last, busy, done,
           underflow, drained_count
  );

  modport master (
    output cmd_valid, cmd_count, cmd_all, stk_data, stk_empty, out_ready,
    input  cmd_ready, stk_pop, out_valid, out_data, out_last, busy, done,
           underflow, drained_count
  );
endinterface

// File: rtl/stack_drainer.sv
// Read-side engine for the LIFO stack: pops N entries (or until empty) on a command
// and streams them top-first on a valid/ready interface, one word every two cycles.
module stack_drainer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  stack_drainer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_all_q, mode_all_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]  drained_count_q, drained_count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;
  logic                  underflow_q, underflow_d;

  logic send_last;
  logic out_fire;

  // stk_empty is sampled live in SEND so it already reflects the pop just taken.
  assign send_last = (state_q == SEND) &&
                     ((!mode_all_q && (remaining_q == '0)) || bus.stk_empty);
  assign out_fire  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d         = state_q;
    mode_all_d      = mode_all_q;
    remaining_d     = remaining_q;
    drained_count_d = drained_count_q;
    out_data_d      = out_data_q;
    underflow_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          remaining_d     = bus.cmd_count;
          mode_all_d      = bus.cmd_all;
          drained_count_d = '0;
          if (!bus.cmd_all && (bus.cmd_count == '0)) begin
            state_d = FINISH;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        if (bus.stk_empty) begin
          state_d     = FINISH;
          underflow_d = !mode_all_q;
        end else begin
          out_data_d = bus.stk_data;
          if (!mode_all_q && (remaining_q != '0)) begin
            remaining_d = remaining_q - CNT_WIDTH'(1);
          end
          state_d = SEND;
        end
      end

      SEND: begin
        if (out_fire) begin
          drained_count_d = drained_count_q + CNT_WIDTH'(1);
          if (send_last) begin
            state_d = FINISH;
            // Counted mode ending on an empty stack still owes words.
            underflow_d = !mode_all_q && (remaining_q != '0);
          end else begin
            state_d = FETCH;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == SEND);
    done_d      = (state_d == FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      mode_all_q      <= 1'b0;
      remaining_q     <= '0;
      drained_count_q <= '0;
      out_data_q      <= '0;
      cmd_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      out_valid_q     <= 1'b0;
      done_q          <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_all_q      <= mode_all_d;
      remaining_q     <= remaining_d;
      drained_count_q <= drained_count_d;
      out_data_q      <= out_data_d;
      cmd_ready_q     <= cmd_ready_d;
      busy_q          <= busy_d;
      out_valid_q     <= out_valid_d;
      done_q          <= done_d;
      underflow_q     <= underflow_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.busy          = busy_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_last      = send_last;
  assign bus.done          = done_q;
  assign bus.underflow     = underflow_q;
  assign bus.drained_count = drained_count_q;
  assign bus.stk_pop       = (state_q == FETCH) && !bus.stk_empty;

endmodule

// File: tb/tb_stack_drainer.sv
// Self-checking bench for stack_drainer: a LIFO environment, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_stack_drainer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stack_drainer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  stack_drainer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // LIFO environment standing in for the real stack.
  logic [DW-1:0] stk_mem[$];
  logic          push_en   = 1'b0;
  logic          stk_clear = 1'b0;
  logic [DW-1:0] push_val  = '0;
  int            pop_cnt   = 0;

  // Reference model state.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  bit            model_active = 0;
  int            exp_n        = 0;
  logic          exp_under    = 1'b0;
  int            exp_lat      = 0;
  int            acc_neg      = 0;
  int            neg_idx      = 0;
  int            stalls       = 0;
  int            pop_base     = 0;
  bit            hold_v       = 0;
  logic [DW-1:0] hold_d       = '0;
  int            done_seen    = 0;
  int            last_lat     = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    if (stk_clear) stk_mem.delete();
    if (bus.stk_pop) begin
      pop_cnt++;
      if (stk_mem.size() > 0) void'(stk_mem.pop_back());
    end
    if (push_en) stk_mem.push_back(push_val);
    bus.stk_data  <= (stk_mem.size() > 0) ? stk_mem[stk_mem.size() - 1] : '0;
    bus.stk_empty <= (stk_mem.size() == 0);
  end

  // Compare process: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      model_active = 0;
      exp_q.delete();
      hold_v = 0;
    end else begin
      bit was_active;
      int lat;
      was_active = model_active;
      neg_idx++;

      checkOutput("busy", bus.busy, was_active);
      checkOutput("cmd_ready", bus.cmd_ready, !was_active);
      if (bus.stk_pop) checkOutput("pop_on_empty", bus.stk_empty, 0);
      if (!was_active) checkOutput("idle_out_valid", bus.out_valid, 0);

      if (hold_v) begin
        checkOutput("hold_valid", bus.out_valid, 1);
        checkOutput("hold_data", bus.out_data, hold_d);
      end

      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_word", bus.out_data, 64'hDEAD_0000);
        end else begin
          checkOutput("out_data", bus.out_data, exp_q[0]);
          checkOutput("out_last", bus.out_last, exp_q.size() == 1);
          void'(exp_q.pop_front());
        end
        got_q.push_back(bus.out_data);
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      if (hold_v) stalls++;

      if (bus.done) begin
        lat = neg_idx - acc_neg;
        checkOutput("done_expected", was_active, 1);
        checkOutput("words_left", exp_q.size(), 0);
        checkOutput("underflow", bus.underflow, exp_under);
        checkOutput("drained_count", bus.drained_count, exp_n);
        checkOutput("pop_count", pop_cnt - pop_base, exp_n);
        checkOutput("done_latency", lat, exp_lat + stalls);
        last_lat = lat;
        done_seen++;
        model_active = 0;
      end else begin
        checkOutput("underflow_no_done", bus.underflow, 0);
      end

      if (!was_active && bus.cmd_valid) begin
        int avail;
        int cnt;
        avail = stk_mem.size();
        cnt   = int'(bus.cmd_count);
        exp_n = bus.cmd_all ? avail : ((cnt < avail) ? cnt : avail);
        exp_under = !bus.cmd_all && (cnt > avail);
        exp_lat = (exp_n == 0 && (bus.cmd_all || cnt != 0)) ? 2 : 2 * exp_n + 1;
        exp_q.delete();
        for (int i = 0; i < exp_n; i++) exp_q.push_back(stk_mem[avail - 1 - i]);
        acc_neg      = neg_idx;
        stalls       = 0;
        pop_base     = pop_cnt;
        model_active = 1;
      end
    end
  end

  task automatic pushWord(input logic [DW-1:0] v);
    push_en  = 1'b1;
    push_val = v;
    @(posedge clk);
    #1 push_en = 1'b0;
  endtask

  task automatic clearStack();
    stk_clear = 1'b1;
    @(posedge clk);
    #1 stk_clear = 1'b0;
  endtask

  task automatic applyStimulus(input int count, input bit all);
    logic [31:0] c;
    c = count;
    got_q.delete();
    bus.cmd_count = c[CW-1:0];
    bus.cmd_all   = all;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int base);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done_seen != base) begin
        seen = 1;
        break;
      end
    end
    checkOutput("done_timeout", seen, 1);
  endtask

  task automatic waitWords(input int n);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (got_q.size() >= n) begin
        seen = 1;
        break;
      end
    end
    checkOutput("word_timeout", seen, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int pbase;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_count = '0;
    bus.cmd_all   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_underflow", bus.underflow, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_drained", bus.drained_count, 0);
    checkOutput("rst_stk_pop", bus.stk_pop, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] counted drain of 2 from 3");
    pushWord(32'h11); pushWord(32'h22); pushWord(32'h33);
    base = done_seen;
    applyStimulus(2, 0);
    waitDone(base);
    checkOutput("t1_words", got_q.size(), 2);
    if (got_q.size() == 2) begin
      checkOutput("t1_word0", got_q[0], 32'h33);
      checkOutput("t1_word1", got_q[1], 32'h22);
    end
    checkOutput("t1_latency", last_lat, 5);
    checkOutput("t1_drained_hold", bus.drained_count, 2);
    checkOutput("t1_stack_top", bus.stk_data, 32'h11);

    $display("[TB] drain all with consumer stall");
    clearStack();
    pushWord(32'hA1); pushWord(32'hA2); pushWord(32'hA3); pushWord(32'hA4);
    base  = done_seen;
    pbase = pop_cnt;
    applyStimulus(0, 1);
    waitWords(1);
    bus.out_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    waitDone(base);
    checkOutput("t2_words", got_q.size(), 4);
    if (got_q.size() == 4) begin
      checkOutput("t2_word0", got_q[0], 32'hA4);
      checkOutput("t2_word3", got_q[3], 32'hA1);
    end
    checkOutput("t2_pops", pop_cnt - pbase, 4);
    checkOutput("t2_stk_empty", bus.stk_empty, 1);

    $display("[TB] counted drain exceeding contents");
    pushWord(32'hB1); pushWord(32'hB2);
    base = done_seen;
    applyStimulus(5, 0);
    waitDone(base);
    checkOutput("t3_words", got_q.size(), 2);
    checkOutput("t3_drained", bus.drained_count, 2);
    checkOutput("t3_latency", last_lat, 5);

    $display("[TB] zero-count and empty-stack commands");
    base = done_seen;
    applyStimulus(0, 0);
    waitDone(base);
    checkOutput("t4_latency", last_lat, 1);
    checkOutput("t4_words", got_q.size(), 0);
    base = done_seen;
    applyStimulus(0, 1);
    waitDone(base);
    checkOutput("t4_all_empty_latency", last_lat, 2);
    base = done_seen;
    applyStimulus(3, 0);
    waitDone(base);
    checkOutput("t4_cnt_empty_latency", last_lat, 2);

    $display("[TB] full stack drain, command ignored while busy");
    for (int i = 0; i < DEPTH; i++) pushWord(32'hC00 + i);
    base = done_seen;
    applyStimulus(0, 1);
    bus.cmd_count = CW'(3);
    bus.cmd_all   = 1'b0;
    bus.cmd_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    waitDone(base);
    checkOutput("t5_words", got_q.size(), 16);
    checkOutput("t5_latency", last_lat, 33);
    if (got_q.size() == 16) checkOutput("t5_first", got_q[0], 32'hC0F);

    $display("[TB] reset during SEND");
    pushWord(32'h61); pushWord(32'h62); pushWord(32'h63);
    applyStimulus(0, 1);
    waitWords(1);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("t6_pre_valid", bus.out_valid, 1);
    checkOutput("t6_pre_drained", bus.drained_count, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_out_valid", bus.out_valid, 0);
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_stk_pop", bus.stk_pop, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("t6_cmd_ready", bus.cmd_ready, 1);
    checkOutput("t6_drained", bus.drained_count, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
